// File: rtl/mlp_pkg.sv
// Shared types, FSM state encoding and the requantise/saturate helper for the streaming MLP layer.
package mlp_pkg;

  localparam int MLP_DW    = 16;
  localparam int MLP_K     = 16;
  localparam int MLP_ACC_W = 2*MLP_DW + $clog2(MLP_K);

  typedef logic signed [MLP_DW-1:0]    data_t;
  typedef logic signed [MLP_ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_OUT} state_t;

  // Adds the Q-aligned bias, floors back to the Q format and clamps to a dw-bit signed range.
  function automatic logic signed [63:0] requant_sat(
    input logic signed [63:0] acc,
    input logic signed [63:0] bias,
    input int                 frac_bits,
    input int                 dw
  );
    logic signed [63:0] s, r, hi, lo;
    s  = acc + (bias <<< frac_bits);
    r  = s >>> frac_bits;
    hi = (64'sd1 <<< (dw-1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw-1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/mlp_mac_lane.sv
// One signed multiply-accumulate lane; clear has priority over enable, result visible the cycle after.
module mlp_mac_lane #(
  parameter int DW    = 16,
  parameter int ACC_W = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clr,
  input  logic                    i_en,
  input  logic signed [DW-1:0]    i_a,
  input  logic signed [DW-1:0]    i_b,
  output logic signed [ACC_W-1:0] o_acc
);

  logic signed [2*DW-1:0]  w_prod;
  logic signed [ACC_W-1:0] r_acc;

  assign w_prod = (2*DW)'(i_a) * (2*DW)'(i_b);
  assign o_acc  = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_acc <= '0;
    else if (i_clr) r_acc <= '0;
    else if (i_en)  r_acc <= r_acc + {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
  end

endmodule

// File: rtl/mlp_stream.sv
// Streaming y = act(x*W + b): LANES MACs swept over OUT_DIM/LANES tiles, (OUT_DIM/LANES)*(HIDDEN_DIM+1) cycles per token.
// Valid/ready both sides; in_ready follows out_ready combinationally in OUT. ReLU built only with MLP_STREAM_RELU_EN.
module mlp_stream
  import mlp_pkg::*;
#(
  parameter int HIDDEN_DIM = 16,
  parameter int OUT_DIM    = 64,
  parameter int LANES      = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 15,
  parameter int NUM_TOKENS = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [DATA_WIDTH*HIDDEN_DIM-1:0]         x,
  input  logic [DATA_WIDTH*HIDDEN_DIM*OUT_DIM-1:0] W,
  input  logic [DATA_WIDTH*OUT_DIM-1:0]            b,
  input  logic                                     act_relu,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [DATA_WIDTH*OUT_DIM-1:0]            y,
  output logic                                     done
);

  localparam int NUM_TILES = OUT_DIM / LANES;
  localparam int ACC_W     = 2*DATA_WIDTH + $clog2(HIDDEN_DIM);
  localparam int K_W       = (HIDDEN_DIM > 1) ? $clog2(HIDDEN_DIM) : 1;
  localparam int T_W       = (NUM_TILES  > 1) ? $clog2(NUM_TILES)  : 1;
  localparam int N_W       = (NUM_TOKENS > 1) ? $clog2(NUM_TOKENS) : 1;
  localparam int XI_W      = $clog2(DATA_WIDTH*HIDDEN_DIM);
  localparam int WI_W      = $clog2(DATA_WIDTH*HIDDEN_DIM*OUT_DIM);
  localparam int YI_W      = $clog2(DATA_WIDTH*OUT_DIM);

  state_t                          r_state, w_state_nxt;
  logic [DATA_WIDTH*HIDDEN_DIM-1:0] r_x;
  logic [K_W-1:0]                  r_k;
  logic [T_W-1:0]                  r_tile;
  logic [N_W-1:0]                  r_tok;
  logic [DATA_WIDTH*OUT_DIM-1:0]   r_y;
  logic                            w_accept, w_out_hs, w_last_k, w_last_tile, w_clr, w_en;
  logic [XI_W-1:0]                 w_xidx;
  logic [YI_W-1:0]                 w_yidx;
  logic signed [DATA_WIDTH-1:0]    w_xk;
  logic [LANES*DATA_WIDTH-1:0]     w_tile;

  assign w_last_k    = (r_k == K_W'(HIDDEN_DIM-1));
  assign w_last_tile = (r_tile == T_W'(NUM_TILES-1));
  assign w_accept    = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign done        = w_out_hs && (r_tok == N_W'(NUM_TOKENS-1));
  assign w_clr       = w_accept || (r_state == S_WB && !w_last_tile);
  assign w_en        = (r_state == S_MAC);
  assign w_xidx      = XI_W'(int'(r_k) * DATA_WIDTH);
  assign w_yidx      = YI_W'(int'(r_tile) * LANES * DATA_WIDTH);
  assign w_xk        = r_x[w_xidx +: DATA_WIDTH];
  assign y           = r_y;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_MAC;
      end
      S_MAC:  if (w_last_k) w_state_nxt = S_WB;
      S_WB:   w_state_nxt = w_last_tile ? S_OUT : S_MAC;
      S_OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? S_MAC : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef MLP_STREAM_RELU_EN
  logic r_relu;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_relu <= 1'b0;
    else if (w_accept) r_relu <= act_relu;
  end
`else
  logic w_unused_relu;
  assign w_unused_relu = act_relu;
`endif

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WI_W-1:0]              w_widx;
    logic [YI_W-1:0]              w_bidx;
    logic signed [DATA_WIDTH-1:0] w_w, w_b, w_sat;
    logic signed [ACC_W-1:0]      w_acc;

    assign w_widx = WI_W'((int'(r_k)*OUT_DIM + int'(r_tile)*LANES + l) * DATA_WIDTH);
    assign w_bidx = YI_W'((int'(r_tile)*LANES + l) * DATA_WIDTH);
    assign w_w    = W[w_widx +: DATA_WIDTH];
    assign w_b    = b[w_bidx +: DATA_WIDTH];

    mlp_mac_lane #(.DW(DATA_WIDTH), .ACC_W(ACC_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_clr),
      .i_en  (w_en),
      .i_a   (w_xk),
      .i_b   (w_w),
      .o_acc (w_acc)
    );

    assign w_sat = DATA_WIDTH'(requant_sat({{(64-ACC_W){w_acc[ACC_W-1]}}, w_acc},
                                           {{(64-DATA_WIDTH){w_b[DATA_WIDTH-1]}}, w_b},
                                           FRAC_BITS, DATA_WIDTH));
`ifdef MLP_STREAM_RELU_EN
    assign w_tile[l*DATA_WIDTH +: DATA_WIDTH] = (r_relu && w_sat[DATA_WIDTH-1]) ? '0 : w_sat;
`else
    assign w_tile[l*DATA_WIDTH +: DATA_WIDTH] = w_sat;
`endif
  end

  // y is only written in WB, so earlier tokens' results persist until overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_k     <= '0;
      r_tile  <= '0;
      r_tok   <= '0;
      r_y     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_x    <= x;
        r_k    <= '0;
        r_tile <= '0;
      end else if (r_state == S_MAC && !w_last_k) begin
        r_k <= r_k + K_W'(1);
      end else if (r_state == S_WB) begin
        r_y[w_yidx +: LANES*DATA_WIDTH] <= w_tile;
        if (!w_last_tile) begin
          r_tile <= r_tile + T_W'(1);
          r_k    <= '0;
        end
      end
      if (w_out_hs) r_tok <= done ? '0 : r_tok + N_W'(1);
    end
  end

endmodule

// File: doc/mlp_stream.md
# mlp_stream

Parametrised successor to the single-shot MLP layer: computes y = act(x·W + b) for a stream of token vectors with valid/ready handshakes on both sides. A tiled bank of LANES multiply-accumulate lanes is time-multiplexed over the output dimension. Fixed-point format, tile width and frame length are configurable. Sits between LayerNorm and the residual adder in the ViT encoder and processes NUM_TOKENS tokens per frame.

## Interface
- HIDDEN_DIM, 16: input vector length K
- OUT_DIM, 64: output vector length N; must be a multiple of LANES
- LANES, 16: parallel MAC lanes, which is the output tile width
- DATA_WIDTH, 16: signed width of x, W, b and y
- FRAC_BITS, 15: fractional bits of x, W, b and y, all in the same Q format
- NUM_TOKENS, 16: tokens per frame, used for `done`
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  x is valid
- in_ready  out  1  block accepts x
- x  in  DATA_WIDTH×HIDDEN_DIM  input vector, captured on the accept edge
- W  in  DATA_WIDTH×(HIDDEN_DIM·OUT_DIM)  flattened weights; W[k·OUT_DIM+n]; must stay stable for the whole frame
- b  in  DATA_WIDTH×OUT_DIM  bias; must stay stable for the whole frame
- act_relu  in  1  selects ReLU; sampled on the accept edge
- out_valid  out  1  y is valid
- out_ready  in  1  downstream accepts y
- y  out  DATA_WIDTH×OUT_DIM  result vector
- done  out  1  one-cycle pulse when the last token of a frame is handed off

## Operation
- States:
  - IDLE: in_ready=1.
  - MAC: iterates k.
  - WB: tile writeback.
  - OUT: out_valid=1.
- Transitions:
  - IDLE→MAC on in_valid. On that edge, latch x and act_relu, set tile=0 and k=0, and clear all accumulators.
  - MAC: each cycle, acc[l] += x[k]·W[k·OUT_DIM + tile·LANES + l] for l in 0..LANES-1. Stay in MAC until k=HIDDEN_DIM-1, then go to WB.
  - WB: requantise the tile into y[tile·LANES+l]. If this is not the last tile, increment tile, clear the accumulators, set k=0 and go to MAC. Otherwise go to OUT.
  - OUT: hold y and out_valid until out_ready.
    - out_ready with no accept → IDLE.
    - out_ready with in_valid → accept the next token directly (go to MAC).
- in_ready = (state==IDLE) || (state==OUT && out_ready). This is combinational from out_ready by design.
- Arithmetic:
  - Products are 2·DATA_WIDTH signed.
  - Accumulator width is ACC_W = 2·DATA_WIDTH + clog2(HIDDEN_DIM). The accumulator never wraps.
  - In WB:
    - Compute s = acc + (sign-extended b <<< FRAC_BITS).
    - Then r = s >>> FRAC_BITS, arithmetic shift with truncation toward −∞.
    - Saturate r to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
    - Apply the activation if enabled.
- Token counter: 0..NUM_TOKENS-1, incremented on each output handshake. On the handshake at count NUM_TOKENS-1, done=1 for that cycle and the counter wraps to 0.
- y changes only in WB. Previous y values stay visible between tokens.
- Reset, at any time including mid-token: state=IDLE, counters=0, accumulators=0, y=0, out_valid=0, done=0. in_ready=1 after reset. A partial token is discarded.

## Timing
- Latency: out_valid rises NUM_TILES·(HIDDEN_DIM+1) edges after the accept edge, where NUM_TILES=OUT_DIM/LANES. With the defaults this is 4·17 = 68 cycles.
- Throughput with out_ready held high: one token per NUM_TILES·(HIDDEN_DIM+1)+1 cycles, because OUT lasts one cycle and overlaps the next accept.
- done is asserted combinationally in the OUT cycle in which the final handshake occurs.
- While out_valid is high and out_ready is low, y, out_valid and done stay stable.

## Configuration
- MLP_STREAM_RELU_EN
  - Defined: when act_relu was latched as 1, negative saturated results become 0.
  - Undefined: act_relu is ignored and y is always the linear saturated result. The port remains present.

## Structure
- The shared package mlp_pkg holds:
  - the acc_t and data_t typedefs derived from the parameters;
  - the state enum;
  - the requantise/saturate function, parametrised by FRAC_BITS.
- Sub-module mlp_mac_lane: one signed MAC with clear and enable, ACC_W wide. It is instantiated LANES times.

## Test plan
All scenarios use the default parameters unless noted.
- Identity: W = 0x7FFF on the diagonal, b=0, x[i]=0x1000 → y[i]=0x0FFF for i<16 and y[i]=0 elsewhere. out_valid rises 68 cycles after accept.
- Saturation: x=0x7FFF and W=0x7FFF everywhere, b=0x7FFF → y=0x7FFF everywhere. With x=0x8000 and W=0x7FFF → y=0x8000.
- ReLU: b=0xC000, x=0, act_relu=1 → y=0 when MLP_STREAM_RELU_EN is defined, else y=0xC000.
- Backpressure and back-to-back: hold out_ready=0 for 10 cycles with in_valid high → y remains stable and in_ready=0. Raising out_ready causes the handoff and accept in the same cycle, and the second token's result is correct.
- Frame: stream 16 tokens with NUM_TOKENS=16 → done pulses exactly once, on the 16th output handshake. The 17th token restarts the count.
- Reset mid-MAC at k=7 of tile 2 → all outputs return to their reset values. The next token produces the correct result with the full 68-cycle latency.
